button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive synchronized-high (or -low) samples required to accept a press (or release); legal range 2..2^CNT_W-1.
REQ-002 Parameter LONG_PRESS_CYCLES, default 50000000, hold time after accepted press before long-press pulse; legal range 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 26, width of each per-channel counter.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 start_stop_raw  input  1  raw, asynchronous, bouncing start/stop button.
REQ-007 clear_raw  input  1  raw, asynchronous, bouncing game-clear button.
REQ-008 start_stop_level  output  1  debounced level of start/stop button.
REQ-009 start_stop_pulse  output  1  one-cycle pulse on accepted start/stop press.
REQ-010 clear_level  output  1  debounced level of clear button.
REQ-011 clear_pulse  output  1  one-cycle pulse on accepted clear press.
REQ-012 start_stop_long  output  1  one-cycle long-press pulse (tied 0 when feature compiled out).
REQ-013 clear_long  output  1  one-cycle long-press pulse (tied 0 when feature compiled out).

Function
REQ-014 Each raw input SHALL pass through a two-flop synchronizer; only the second flop output (s) feeds the channel logic.
REQ-015 Each channel SHALL run an identical FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT and a CNT_W-bit counter.
REQ-016 IDLE: s=1 -> PRESS_WAIT with counter=1; else stay.
REQ-017 PRESS_WAIT: s=0 -> IDLE, counter=0; s=1 and counter==DEBOUNCE_CYCLES-1 -> PRESSED, level<=1, pulse<=1, counter=0; else counter+1.
REQ-018 PRESSED: s=0 -> RELEASE_WAIT, counter=1; else stay, level held 1.
REQ-019 RELEASE_WAIT: s=1 -> PRESSED, counter=0 (bounce ignored, no new pulse); s=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE, level<=0; else counter+1.
REQ-020 Latency: with raw held steady, level and pulse SHALL change on exactly the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge sampling the new raw value as edge 1.
REQ-021 Pulse outputs SHALL be registered and high for exactly one cycle per accepted press; no pulse on release.
REQ-022 Any glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no level change and no pulse.
REQ-023 Simultaneous events: if clear_pulse and start_stop_pulse would assert in the same cycle, clear_pulse SHALL assert and start_stop_pulse SHALL be suppressed for that press (start_stop_level still rises).
REQ-024 Counters SHALL never wrap; saturation is impossible by parameter range.

Reset
REQ-025 While reset=1: synchronizer flops 0, all FSMs IDLE, counters 0, every output 0.
REQ-026 Reset asserted mid-press SHALL abort the press with no pulse; if the raw button is still held after reset deasserts, it SHALL be re-debounced and produce a pulse after REQ-020 latency.

Configuration
REQ-027 Macro BUTTON_CONDITIONER_LONG_PRESS_EN defined: in PRESSED the counter SHALL increment each cycle from 0; on reaching LONG_PRESS_CYCLES the channel's *_long output SHALL pulse one cycle, once per press; counter then holds until release.
REQ-028 Macro undefined: long-press counting logic absent; start_stop_long and clear_long constant 0; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10)
REQ-029 start_stop_raw 0->1 held -> start_stop_level and start_stop_pulse rise on edge 6; pulse low on edge 7; level stays 1.
REQ-030 start_stop_raw pulses high for 3 cycles, then low -> no pulse, level stays 0.
REQ-031 Press accepted, raw drops 2 cycles then returns high -> level stays 1, no second pulse; full release held low -> level falls 5 edges after release sampled, no pulse.
REQ-032 Both raws rise on the same edge and held -> clear_pulse=1, start_stop_pulse=0 on edge 6; both levels=1.
REQ-033 Reset asserted on edge 4 of a press with raw held, deasserted 2 cycles later -> all outputs 0 immediately on reset; pulse on edge 6 counted from first post-reset edge.
REQ-034 LONG_PRESS_EN defined, clear_raw held -> clear_pulse at edge 6, clear_long single pulse 10 cycles later, none afterwards; macro undefined -> clear_long never asserts.

Source files
------------

// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner: synchronize, debounce, press pulse, optional long-press pulse.
// Long-press detection is compiled in only when BUTTON_CONDITIONER_LONG_PRESS_EN is defined.

module button_conditioner_channel #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int CNT_W             = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic accept,
  output logic long_pulse
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             s;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // Press acceptance is combinational so the top can arbitrate pulses between channels.
  assign accept = (state == PRESS_WAIT) && s && (cnt == DEB_LAST);

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_CNT  = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic long_q;
  logic long_done;
  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0 & (LONG_PRESS_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
      long_q    <= 1'b0;
      long_done <= 1'b0;
`endif
    end else begin
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
      long_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= PRESSED;
            level <= 1'b1;
            cnt   <= '0;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
            long_done <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_W'(1);
          end else begin
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
            // Counter parks at LONG_CNT; long_done keeps a bounce-restarted count from re-firing.
            if (cnt != LONG_CNT) cnt <= cnt + 1'b1;
            if (cnt == LONG_LAST && !long_done) begin
              long_q    <= 1'b1;
              long_done <= 1'b1;
            end
`endif
          end
        end
        default: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
            level <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int CNT_W             = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic start_stop_raw,
  input  logic clear_raw,
  output logic start_stop_level,
  output logic start_stop_pulse,
  output logic clear_level,
  output logic clear_pulse,
  output logic start_stop_long,
  output logic clear_long
);

  logic ss_accept;
  logic clr_accept;

  button_conditioner_channel #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
    .CNT_W            (CNT_W)
  ) u_start_stop (
    .clk       (clk),
    .reset     (reset),
    .raw       (start_stop_raw),
    .level     (start_stop_level),
    .accept    (ss_accept),
    .long_pulse(start_stop_long)
  );

  button_conditioner_channel #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
    .CNT_W            (CNT_W)
  ) u_clear (
    .clk       (clk),
    .reset     (reset),
    .raw       (clear_raw),
    .level     (clear_level),
    .accept    (clr_accept),
    .long_pulse(clear_long)
  );

  // Clear wins a same-cycle press; the start/stop press is still reflected in its level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_stop_pulse <= 1'b0;
      clear_pulse      <= 1'b0;
    end else begin
      start_stop_pulse <= ss_accept & ~clr_accept;
      clear_pulse      <= clr_accept;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10).
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 10;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start_stop_raw, clear_raw;
  logic start_stop_level, start_stop_pulse, clear_level, clear_pulse;
  logic start_stop_long, clear_long;

  int errors = 0;
  int checks = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .CNT_W            (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_stop_raw  (start_stop_raw),
    .clear_raw       (clear_raw),
    .start_stop_level(start_stop_level),
    .start_stop_pulse(start_stop_pulse),
    .clear_level     (clear_level),
    .clear_pulse     (clear_pulse),
    .start_stop_long (start_stop_long),
    .clear_long      (clear_long)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 = start/stop, 1 = clear.
  logic m_p1[2], m_p2[2], m_lvl[2], m_prev[2], m_done[2];
  int   m_run[2], m_hold[2];
  logic e_pls[2], e_long[2];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_p1[c] = 1'b0; m_p2[c] = 1'b0; m_lvl[c] = 1'b0; m_prev[c] = 1'b0;
      m_done[c] = 1'b0; m_run[c] = 0; m_hold[c] = 0;
      e_pls[c] = 1'b0; e_long[c] = 1'b0;
    end
  endfunction

  // Level flips after DEB consecutive synchronized samples disagreeing with it;
  // long fires once when a held press has lasted LONG samples past acceptance or last bounce.
  function automatic void model_edge(input logic ss, input logic clr);
    logic raw[2];
    logic acc[2];
    logic s;
    raw[0] = ss; raw[1] = clr;
    for (int c = 0; c < 2; c++) begin
      s = m_p2[c]; m_p2[c] = m_p1[c]; m_p1[c] = raw[c];
      acc[c] = 1'b0; e_long[c] = 1'b0;
      if (s != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin
          m_lvl[c] = s; m_run[c] = 0;
          if (s) begin acc[c] = 1'b1; m_hold[c] = 0; m_done[c] = 1'b0; end
        end
      end else begin
        m_run[c] = 0;
        if (s) begin
          m_hold[c] = m_prev[c] ? m_hold[c] + 1 : 0;
          if (m_hold[c] == LONG && !m_done[c]) begin e_long[c] = LONG_EN; m_done[c] = 1'b1; end
        end
      end
      m_prev[c] = s;
    end
    e_pls[1] = acc[1];
    e_pls[0] = acc[0] && !acc[1];
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("model ss_level", start_stop_level, m_lvl[0]);
    check("model ss_pulse", start_stop_pulse, e_pls[0]);
    check("model clr_level", clear_level, m_lvl[1]);
    check("model clr_pulse", clear_pulse, e_pls[1]);
    check("model ss_long", start_stop_long, e_long[0]);
    check("model clr_long", clear_long, e_long[1]);
  endtask

  task automatic step(input logic ss, input logic clr);
    start_stop_raw = ss;
    clear_raw      = clr;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(ss, clr);
    #1;
    compare_all();
  endtask

  task automatic async_reset_on();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
  endtask

  typedef struct {
    logic ss, clr;
    logic ss_lvl, ss_pls, clr_lvl, clr_pls;
  } vec_t;
  vec_t tbl[32];

  initial begin
    int pc, lc;
    logic rs, rc;
    int ls, lcnt;

    for (int e = 1; e <= 8; e++) begin
      tbl[e-1]    = '{1'b1, 1'b0, e >= 6, e == 6, 1'b0, 1'b0};
      tbl[8+e-1]  = '{1'b0, 1'b0, e < 6, 1'b0, 1'b0, 1'b0};
      tbl[16+e-1] = '{1'b1, 1'b1, e >= 6, 1'b0, e >= 6, e == 6};
      tbl[24+e-1] = '{1'b0, 1'b0, e < 6, 1'b0, e < 6, 1'b0};
    end

    start_stop_raw = 1'b0;
    clear_raw      = 1'b0;
    async_reset_on();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b0;

    // Press latency, release latency, simultaneous press priority
    for (int i = 0; i < 32; i++) begin
      step(tbl[i].ss, tbl[i].clr);
      check($sformatf("tbl[%0d] ss_level", i), start_stop_level, tbl[i].ss_lvl);
      check($sformatf("tbl[%0d] ss_pulse", i), start_stop_pulse, tbl[i].ss_pls);
      check($sformatf("tbl[%0d] clr_level", i), clear_level, tbl[i].clr_lvl);
      check($sformatf("tbl[%0d] clr_pulse", i), clear_pulse, tbl[i].clr_pls);
    end

    // Short glitch is rejected
    pc = 0;
    for (int i = 0; i < 3; i++) begin step(1'b1, 1'b0); pc += int'(start_stop_pulse); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      pc += int'(start_stop_pulse);
      check("glitch level", start_stop_level, 1'b0);
    end
    check("glitch no pulse", pc == 0, 1'b1);

    // Bounce while pressed, then full release
    pc = 0;
    for (int i = 0; i < 6; i++) begin step(1'b1, 1'b0); pc += int'(start_stop_pulse); end
    check("bounce accepted", start_stop_level, 1'b1);
    for (int i = 0; i < 2; i++) begin step(1'b0, 1'b0); pc += int'(start_stop_pulse); end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      pc += int'(start_stop_pulse);
      check("bounce level", start_stop_level, 1'b1);
    end
    check("bounce one pulse", pc == 1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0);
      check("release level", start_stop_level, i < 6);
      check("release no pulse", start_stop_pulse, 1'b0);
    end

    // Long press on clear
    lc = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 1'b1);
      check("long clr_pulse", clear_pulse, i == 6);
      check("long clr_long", clear_long, LONG_EN && (i == 6 + LONG));
      lc += int'(clear_long);
    end
    check("long count", lc == (LONG_EN ? 1 : 0), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

    // Reset mid-press aborts; held button re-debounced afterwards
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    async_reset_on();
    check("rst ss_level", start_stop_level, 1'b0);
    check("rst ss_pulse", start_stop_pulse, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      check("post-rst ss_pulse", start_stop_pulse, i == 6);
      check("post-rst ss_level", start_stop_level, i >= 6);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

    // Randomized runs against the model
    rs = 1'b0; rc = 1'b0; ls = 0; lcnt = 0;
    for (int n = 0; n < 1500; n++) begin
      if (ls == 0) begin rs = 1'($urandom_range(0, 1)); ls = $urandom_range(1, 16); end
      if (lcnt == 0) begin rc = 1'($urandom_range(0, 1)); lcnt = $urandom_range(1, 16); end
      if ($urandom_range(0, 199) == 0) begin
        async_reset_on();
        step(rs, rc);
        reset = 1'b0;
      end else begin
        step(rs, rc);
      end
      ls--; lcnt--;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
